// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle HI/LO multiply/divide unit (mult, multu, div, divu,
//            mthi, mtlo). Defining MD_UNIT_MADD_EN adds madd/maddu/msub/msubu.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
    localparam logic [3:0] c_op_madd  = 4'd7;
    localparam logic [3:0] c_op_maddu = 4'd8;
    localparam logic [3:0] c_op_msub  = 4'd9;
    localparam logic [3:0] c_op_msubu = 4'd10;

    localparam int c_cnt_max = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cw      = $clog2(c_cnt_max + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;

    logic              w_op_valid;
    logic              w_is_div;
    logic [63:0]       w_prod_s;
    logic [63:0]       w_prod_u;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [31:0]       w_dvs_s;
    logic [31:0]       w_dvs_u;
    logic [31:0]       w_quot_s;
    logic [31:0]       w_rem_s;
    logic [31:0]       w_quot_u;
    logic [31:0]       w_rem_u;
    logic [31:0]       w_res_hi;
    logic [31:0]       w_res_lo;

    always_comb begin
        w_op_valid = 1'b0;
        case (op)
            c_op_mult, c_op_multu, c_op_div, c_op_divu,
            c_op_mthi, c_op_mtlo: w_op_valid = 1'b1;
`ifdef MD_UNIT_MADD_EN
            c_op_madd, c_op_maddu,
            c_op_msub, c_op_msubu: w_op_valid = 1'b1;
`endif
            default: w_op_valid = 1'b0;
        endcase
    end

    assign w_is_div = (op == c_op_div) || (op == c_op_divu);

    assign w_prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Dividing the overflow case by 1 yields exactly lo=0x80000000, hi=0 and
    // keeps the simulator from trapping on INT_MIN / -1.
    assign w_div_zero = (b_q == 32'd0);
    assign w_div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign w_dvs_s    = (w_div_zero || w_div_ovf) ? 32'd1 : b_q;
    assign w_dvs_u    = w_div_zero ? 32'd1 : b_q;
    assign w_quot_s   = $signed(a_q) / $signed(w_dvs_s);
    assign w_rem_s    = $signed(a_q) % $signed(w_dvs_s);
    assign w_quot_u   = a_q / w_dvs_u;
    assign w_rem_u    = a_q % w_dvs_u;

    always_comb begin
        w_res_hi = hi_q;
        w_res_lo = lo_q;
        case (op_q)
            c_op_mult:  {w_res_hi, w_res_lo} = w_prod_s;
            c_op_multu: {w_res_hi, w_res_lo} = w_prod_u;
            c_op_div: begin
                if (!w_div_zero) begin
                    w_res_lo = w_quot_s;
                    w_res_hi = w_rem_s;
                end
            end
            c_op_divu: begin
                if (!w_div_zero) begin
                    w_res_lo = w_quot_u;
                    w_res_hi = w_rem_u;
                end
            end
`ifdef MD_UNIT_MADD_EN
            c_op_madd:  {w_res_hi, w_res_lo} = {hi_q, lo_q} + w_prod_s;
            c_op_maddu: {w_res_hi, w_res_lo} = {hi_q, lo_q} + w_prod_u;
            c_op_msub:  {w_res_hi, w_res_lo} = {hi_q, lo_q} - w_prod_s;
            c_op_msubu: {w_res_hi, w_res_lo} = {hi_q, lo_q} - w_prod_u;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (start && !busy_q && w_op_valid) begin
                    if (op == c_op_mthi) begin
                        hi_d = a;
                    end else if (op == c_op_mtlo) begin
                        lo_d = a;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = w_is_div ? c_cw'(DIV_CYCLES) : c_cw'(MULT_CYCLES);
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - c_cw'(1);
                if (cnt_q == c_cw'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    hi_d    = w_res_hi;
                    lo_d    = w_res_lo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
